// File: rtl/audio_pkg.sv
// Shared audio-path constants and the I2S slot encoding.
package audio_pkg;
  localparam int unsigned SAMPLE_WIDTH   = 16;
  localparam int unsigned I2S_SLOT_WIDTH = 32;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } slot_e;
endpackage

// File: rtl/i2s_transmitter_clkgen.sv
// BCLK divider: toggles bclk every bclk_half clk cycles and reports each edge
// as a one-clk strobe coincident with the clk edge that makes the toggle.
module i2s_clkgen #(
  parameter int unsigned bclk_half = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bclk,
  output logic o_rise,
  output logic o_fall
);
  localparam int unsigned CW = (bclk_half > 1) ? $clog2(bclk_half) : 1;

  logic [CW-1:0] r_div;
  logic          r_bclk;
  logic          w_tc;

  assign w_tc = (r_div == CW'(bclk_half - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_bclk = r_bclk;
  assign o_rise = w_tc & ~r_bclk;
  assign o_fall = w_tc & r_bclk;
endmodule

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S serializer with a single pending-sample register and
// underrun/overflow reporting; all I2S-side state moves on BCLK falls.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned sample_width = SAMPLE_WIDTH,
  parameter int unsigned slot_width   = I2S_SLOT_WIDTH,
  parameter int unsigned bclk_half    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [sample_width-1:0] sample_in,
  output logic                    ready,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    frame_start,
  output logic                    underrun,
  output logic                    overflow
);
  localparam int unsigned FRAME = 2 * slot_width;
  localparam int unsigned BW    = (FRAME > 2) ? $clog2(FRAME) : 1;

  logic                    w_bclk;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_unused;
  logic [BW-1:0]           r_bit_cnt;
  logic [BW-1:0]           w_n;
  logic [BW-1:0]           w_j;
  logic                    w_load;
  logic                    w_sd;
  logic [sample_width-1:0] w_shifted;
  slot_e                   r_lrclk;
  slot_e                   w_slot;
  logic                    r_sdata;
  logic [sample_width-1:0] r_frame;
  logic [sample_width-1:0] r_pend;
  logic                    r_pend_full;
  logic                    r_frame_start;
  logic                    r_underrun;
  logic                    r_overflow;

  i2s_clkgen #(.bclk_half(bclk_half)) u_clkgen (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_bclk (w_bclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Data only changes on falls, so the rise strobe has no consumer here.
  assign w_unused = w_rise;

  // The bit being driven after a fall is indexed by the pre-increment count,
  // which is exactly the one-bit-delayed position (n-1) mod frame.
  always_comb begin
    w_n       = (r_bit_cnt == BW'(FRAME - 1)) ? '0 : r_bit_cnt + 1'b1;
    w_j       = (r_bit_cnt >= BW'(slot_width)) ? r_bit_cnt - BW'(slot_width) : r_bit_cnt;
    w_shifted = r_frame << w_j;
    w_sd      = w_shifted[sample_width-1];
    w_slot    = (w_n >= BW'(slot_width)) ? RIGHT : LEFT;
    w_load    = w_fall && (w_n == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt     <= BW'(FRAME - 1);
      r_lrclk       <= LEFT;
      r_sdata       <= 1'b0;
      r_frame       <= '0;
      r_pend        <= '0;
      r_pend_full   <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overflow    <= 1'b0;

      if (w_fall) begin
        r_bit_cnt <= w_n;
        r_lrclk   <= w_slot;
        r_sdata   <= w_sd;
      end

      if (w_load) begin
        r_frame_start <= 1'b1;
        r_underrun    <= ~r_pend_full;
        if (r_pend_full) r_frame <= r_pend;
      end

      // A load in the same cycle drains the old sample first, so a
      // simultaneous valid refills the register without overflowing.
      if (valid) begin
        r_pend      <= sample_in;
        r_pend_full <= 1'b1;
        r_overflow  <= r_pend_full & ~w_load;
      end else if (w_load) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  assign ready       = ~r_pend_full;
  assign i2s_bclk    = w_bclk;
  assign i2s_lrclk   = r_lrclk;
  assign i2s_sdata   = r_sdata;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;
  assign overflow    = r_overflow;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter (bclk_half=2, slot_width=32).
module tb_i2s_transmitter;
  localparam int H  = 2;
  localparam int SL = 32;
  localparam int FR = 2 * SL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        ready, i2s_bclk, i2s_lrclk, i2s_sdata;
  logic        frame_start, underrun, overflow;

  always #5 clk = ~clk;

  i2s_transmitter #(.sample_width(16), .slot_width(SL), .bclk_half(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .sample_in   (sample_in),
    .ready       (ready),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .frame_start (frame_start),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  int          total = 0;
  int          bad = 0;
  // Model state: c counts clk edges since reset release.
  int          c = 0;
  logic        m_full = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_word = '0;
  logic        e_fs = 1'b0, e_ur = 1'b0, e_ov = 1'b0;
  logic [15:0] cap_l = '0, cap_r = '0;

  function automatic logic [6:0] outv();
    return {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overflow, ready};
  endfunction

  // Expected outputs from the cycle index: falls at c = 2H*k, slot index n = k-1.
  function automatic logic [6:0] expv();
    int   k, n, j;
    logic b, l, s;
    b = ((c / H) % 2) == 1;
    k = c / (2 * H);
    l = 1'b0;
    s = 1'b0;
    if (k > 0) begin
      n = (k - 1) % FR;
      l = (n >= SL);
      j = ((n + FR - 1) % FR) % SL;
      if (j < 16) s = m_word[15-j];
    end
    return {b, l, s, e_fs, e_ur, e_ov, !m_full};
  endfunction

  task automatic cyc(input logic v, input logic [15:0] d);
    logic ld;
    int   n;
    valid     = v;
    sample_in = d;
    @(posedge clk);
    c++;
    ld   = (c >= 2 * H) && (((c - 2 * H) % (2 * H * FR)) == 0);
    e_fs = ld;
    e_ur = ld && !m_full;
    e_ov = v && m_full && !ld;
    if (ld && m_full) m_word = m_pend;
    if (v) begin
      m_pend = d;
      m_full = 1'b1;
    end else if (ld) begin
      m_full = 1'b0;
    end
    #1;
    valid = 1'b0;
    if (c % (2 * H) == 0) begin
      n = ((c / (2 * H)) - 1) % FR;
      if (n >= 1 && n <= 16) cap_l[16-n] = i2s_sdata;
      if (n >= SL + 1 && n <= SL + 16) cap_r[SL+16-n] = i2s_sdata;
    end
  endtask

  task automatic run_to(input int target, input int vprob);
    while (c < target) begin
      if (vprob > 0 && $urandom_range(vprob - 1, 0) == 0) cyc(1'b1, 16'($urandom));
      else cyc(1'b0, '0);
      total++;
      if (outv() !== expv()) begin
        bad++;
        $display("FAIL cycle c=%0d got=%b exp=%b", c, outv(), expv());
      end
    end
  endtask

  task automatic hold_reset(input int n);
    rst   = 1'b1;
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      c = 0; m_full = 1'b0; m_pend = '0; m_word = '0;
      e_fs = 1'b0; e_ur = 1'b0; e_ov = 1'b0;
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset(3);
    total++;
    if (outv() !== 7'b0000001) begin
      bad++; $display("FAIL reset got=%b exp=0000001", outv());
    end
    run_to(2, 0);
    total++;
    if (i2s_bclk !== 1'b1) begin
      bad++; $display("FAIL bclk_rise got=%b exp=1", i2s_bclk);
    end
    run_to(4, 0);
    total++;
    if ({i2s_bclk, frame_start, underrun, i2s_sdata} !== 4'b0110) begin
      bad++; $display("FAIL first_load got=%b exp=0110", {i2s_bclk, frame_start, underrun, i2s_sdata});
    end
  endtask

  task automatic test_first_frame();
    hold_reset(2);
    cyc(1'b1, 16'hA5C3);
    run_to(4, 0);
    total++;
    if ({frame_start, underrun, ready} !== 3'b101) begin
      bad++; $display("FAIL load_a5c3 got=%b exp=101", {frame_start, underrun, ready});
    end
    run_to(131, 0);
    total++;
    if (i2s_lrclk !== 1'b0) begin
      bad++; $display("FAIL lrclk_n31 got=%b exp=0", i2s_lrclk);
    end
    run_to(132, 0);
    total++;
    if (i2s_lrclk !== 1'b1) begin
      bad++; $display("FAIL lrclk_n32 got=%b exp=1", i2s_lrclk);
    end
    run_to(200, 0);
    total++;
    if (cap_l !== 16'hA5C3 || cap_r !== 16'hA5C3) begin
      bad++; $display("FAIL a5c3_slots got=%h/%h exp=a5c3/a5c3", cap_l, cap_r);
    end
  endtask

  task automatic test_underrun_repeat();
    run_to(260, 0);
    total++;
    if ({frame_start, underrun} !== 2'b11) begin
      bad++; $display("FAIL repeat_underrun got=%b exp=11", {frame_start, underrun});
    end
    cap_l = '0;
    run_to(456, 0);
    total++;
    if (cap_l !== 16'hA5C3) begin
      bad++; $display("FAIL repeat_word got=%h exp=a5c3", cap_l);
    end
  endtask

  task automatic test_overflow();
    run_to(520, 0);
    cyc(1'b1, 16'h1234);
    total++;
    if ({overflow, ready} !== 2'b00) begin
      bad++; $display("FAIL first_valid got=%b exp=00", {overflow, ready});
    end
    run_to(599, 0);
    cyc(1'b1, 16'h8000);
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_pulse got=%b exp=1", overflow);
    end
    run_to(772, 0);
    total++;
    if ({frame_start, underrun} !== 2'b10) begin
      bad++; $display("FAIL load_8000 got=%b exp=10", {frame_start, underrun});
    end
    run_to(968, 0);
    total++;
    if (cap_l !== 16'h8000 || cap_r !== 16'h8000) begin
      bad++; $display("FAIL newest_wins got=%h/%h exp=8000/8000", cap_l, cap_r);
    end
  endtask

  task automatic test_load_collision();
    run_to(1099, 0);
    cyc(1'b1, 16'h0001);
    run_to(1283, 0);
    cyc(1'b1, 16'h7FFF);
    total++;
    if ({frame_start, underrun, overflow, ready} !== 4'b1000) begin
      bad++; $display("FAIL collision got=%b exp=1000", {frame_start, underrun, overflow, ready});
    end
    run_to(1480, 0);
    total++;
    if (cap_l !== 16'h0001) begin
      bad++; $display("FAIL collision_old got=%h exp=0001", cap_l);
    end
    run_to(1736, 0);
    total++;
    if (cap_l !== 16'h7FFF || cap_r !== 16'h7FFF) begin
      bad++; $display("FAIL collision_new got=%h/%h exp=7fff/7fff", cap_l, cap_r);
    end
  endtask

  task automatic test_reset_midframe();
    hold_reset(2);
    run_to(9, 0);
    cyc(1'b1, 16'hBEEF);
    run_to(84, 0);
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL pending_before_reset got=%b exp=0", ready);
    end
    hold_reset(1);
    total++;
    if (outv() !== 7'b0000001) begin
      bad++; $display("FAIL midframe_reset got=%b exp=0000001", outv());
    end
    hold_reset(1);
    run_to(4, 0);
    total++;
    if ({frame_start, underrun} !== 2'b11) begin
      bad++; $display("FAIL no_stale_load got=%b exp=11", {frame_start, underrun});
    end
    run_to(200, 0);
    total++;
    if (cap_l !== 16'h0000 || cap_r !== 16'h0000) begin
      bad++; $display("FAIL no_stale_word got=%h/%h exp=0000/0000", cap_l, cap_r);
    end
  endtask

  task automatic test_random();
    run_to(1400, 40);
    run_to(2200, 8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_underrun_repeat();
    test_overflow();
    test_load_collision();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
